// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word fetches and buffers {pc, inst} pairs for decode.
// Optional saturating decode-stall counter on port stall_cnt, enabled by defining FETCH_STALL_CNT_EN.
module fetch_unit #(
  parameter int unsigned           XLEN       = 32,
  parameter logic [XLEN-1:0]       RESET_PC   = '0,
  parameter int unsigned           FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
`ifdef FETCH_STALL_CNT_EN
  output logic [31:0]     stall_cnt,
`endif
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  pc;
  logic             inflight;
  logic [XLEN-1:0]  inflight_addr;
  logic             discard;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic [XLEN-1:0]  pc_mem   [FIFO_DEPTH];
  logic [31:0]      inst_mem [FIFO_DEPTH];

  logic has_room;
  logic issue;
  logic push;
  logic pop;

  // Credit check uses the registered count only, so a same-cycle pop never frees a slot early.
  always_comb begin
    has_room  = (32'(count) + 32'(inflight)) < 32'(FIFO_DEPTH);
    issue     = rst_n && !redirect_valid && has_room;
    push      = rst_n && !redirect_valid && inflight && !discard;
    out_valid = rst_n && (count != '0);
    pop       = out_valid && out_ready;
    imem_req  = issue;
    imem_addr = rst_n ? pc : '0;
    out_pc    = out_valid ? pc_mem[rd_ptr] : '0;
    out_inst  = out_valid ? inst_mem[rd_ptr] : '0;
  end

  // NOTE: non-blocking assignments make every register see pre-edge values; a later
  // assignment in the block overrides an earlier one, which is how redirect beats issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      discard       <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_addr <= pc;
        pc            <= pc + XLEN'(4);
      end

      if (redirect_valid) begin
        pc      <= redirect_pc & ~XLEN'(3);
        discard <= 1'b1;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count   <= '0;
      end else begin
        discard <= 1'b0;
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: buffer storage is deliberately not reset; count gates out_valid/out_pc/out_inst,
  // so stale entries are never observable.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= inflight_addr;
      inst_mem[wr_ptr] <= imem_rdata;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  // Counts cycles where decode is offered an instruction but holds it off; survives redirects.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
